multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multicycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back. Each cycle it drives the datapath selects: write-data mux `memtoreg`, `reg_dst`, ALU sources, `pc_src` and the write enables. It sits beside the register file / write-data mux and the unified instruction/data memory, and stalls on a memory-ready handshake.

## Interface
Parameters:
- `NUM_STATES`, 14: number of FSM states (fixes the 4-bit encoding; not meant to be overridden).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `opcode`  in  6  instruction register bits [31:26], valid from DECODE onward.
- `funct`  in  6  instruction register bits [5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read/write this cycle.
- `pc_write`  out  1  PC load enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction register load.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  2  destination register: 00 = rt, 01 = rd, 10 = $31.
- `memtoreg`  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC+4.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target, 11 = register A.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  current state, for debug.

## Operation
State encoding:
- FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, ADDI_EXEC 9, ADDI_WB 10, JUMP 11, JAL 12, JR 13.

Per-state outputs:
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write = mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target). Dispatch on opcode:
  - lw 100011 / sw 101011 → MEM_ADDR.
  - R-type 000000: funct 001000 → JR; any other supported funct → EXECUTE.
  - beq 000100 → BRANCH.
  - addi 001000 → ADDI_EXEC.
  - j 000010 → JUMP.
  - jal 000011 → JAL.
  - Anything else → FETCH with illegal_op=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: iord=1, mem_read=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, memtoreg=01. Then FETCH.
- MEM_WRITE: iord=1, mem_write=1. Hold until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALU_WB.
- ALU_WB: reg_write=1, reg_dst=01, memtoreg=00. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero. Then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=00, memtoreg=00. Then FETCH.
- JUMP: pc_write=1, pc_src=10. Then FETCH.
- JAL: reg_write=1, reg_dst=10, memtoreg=10, pc_write=1, pc_src=10. Then FETCH. PC+4 is the value already held in the PC since FETCH.
- JR: pc_write=1, pc_src=11. Then FETCH.

Global output rules:
- Every output not listed for a state is 0 in that state.
- Outputs are a combinational decode of the state register, plus mem_ready/zero where stated.

## Timing
- Reset: the state register goes to FETCH immediately on rst assertion, with no clock needed. All outputs take their FETCH values; pc_write and ir_write follow mem_ready.
- Reset mid-instruction aborts it. No write enable may assert after rst rises.
- Cycle counts with zero memory wait, FETCH through the last state:
  - lw 5, sw 4, R-type 4, addi 4.
  - beq, j, jal, jr 3.
  - Illegal opcode 2.
- Each low cycle of mem_ready in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. During a stall the request stays asserted and the address selects do not change.
- mem_ready is ignored in all other states.
- illegal_op is high only in the DECODE cycle that detects the bad opcode.
- reg_write and pc_write are never asserted in the same cycle as mem_write.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum;
  - opcode/funct constants;
  - the memtoreg, reg_dst, alu_src_b, pc_src and alu_op encodings, shared with the write-data mux and ALU control.
- Sub-module `main_decoder`: combinational opcode/funct → next-state dispatch and illegal detection, used only by DECODE.
- The top holds the state register and the output decode.

## Test plan
- rst high mid-MEM_READ, then released with mem_ready=1 → state=0 during reset; first FETCH then asserts ir_write=1, pc_write=1.
- lw, with mem_ready low for 2 cycles in FETCH and 1 in MEM_READ → 8 cycles total; MEM_WB shows reg_write=1, memtoreg=01, reg_dst=00.
- beq with zero=1, then with zero=0 → BRANCH pc_write=1 with pc_src=01, then pc_write=0; each takes 3 cycles.
- jal (000011) → JAL cycle has reg_write=1, reg_dst=10, memtoreg=10, pc_write=1, pc_src=10.
- R-type add (funct 100000), then jr (funct 001000) → ALU_WB with memtoreg=00, reg_dst=01; then JR with pc_src=11.
- Opcode 111111 → illegal_op pulses one cycle in DECODE, returns to FETCH, and no write enable asserts.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: state, opcode/funct and datapath select encodings for the multicycle MIPS control
package mips_pkg;
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    ADDI_EXEC = 4'd9,
    ADDI_WB   = 4'd10,
    JUMP      = 4'd11,
    JAL       = 4'd12,
    JR        = 4'd13
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC4    = 2'b10;
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fields, memory handshake and datapath selects
interface multicycle_control_if;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal_op;
  logic [1:0] reg_dst, memtoreg, alu_src_b, alu_op, pc_src;
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, memtoreg,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op
  );
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, memtoreg,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op
  );
endinterface

// File: rtl/main_decoder.sv
// main_decoder: opcode/funct dispatch out of DECODE plus unsupported-instruction detection
module main_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     next,
  output logic       illegal
);
  logic fn_ok;
  always_comb begin
    fn_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    next = FETCH;
    case (opcode)
      OP_LW, OP_SW: next = MEM_ADDR;
      OP_RTYPE:     next = funct == FN_JR ? JR : fn_ok ? EXECUTE : FETCH;
      OP_BEQ:       next = BRANCH;
      OP_ADDI:      next = ADDI_EXEC;
      OP_J:         next = JUMP;
      OP_JAL:       next = JAL;
      default:      next = FETCH;
    endcase
    illegal = next == FETCH;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM of the multicycle MIPS datapath, Moore decode with mem_ready/zero qualifiers
module multicycle_control
  import mips_pkg::*;
#(
  parameter int NUM_STATES = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  multicycle_control_if.master          bus,
  output logic [$clog2(NUM_STATES)-1:0] state
);
  state_t cur, nxt, dec_next;
  logic dec_illegal;
  main_decoder u_dec (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .next   (dec_next),
    .illegal(dec_illegal)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= FETCH;
    else cur <= nxt;
  assign state = cur;
  always_comb begin
    nxt = FETCH;
    bus.pc_write = 1'b0;
    bus.iord = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_dst = RD_RT;
    bus.memtoreg = MTR_ALUOUT;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = SRCB_B;
    bus.alu_op = ALU_ADD;
    bus.pc_src = PC_ALU;
    bus.illegal_op = 1'b0;
    case (cur)
      FETCH: begin
        bus.mem_read = 1'b1;
        bus.alu_src_b = SRCB_4;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
        nxt = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = SRCB_IMM_SL2;
        bus.illegal_op = dec_illegal;
        nxt = dec_next;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        nxt = bus.opcode == OP_SW ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        bus.iord = 1'b1;
        bus.mem_read = 1'b1;
        nxt = bus.mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        bus.reg_write = 1'b1;
        bus.memtoreg = MTR_MDR;
      end
      MEM_WRITE: begin
        bus.iord = 1'b1;
        bus.mem_write = 1'b1;
        nxt = bus.mem_ready ? FETCH : MEM_WRITE;
      end
      EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op = ALU_FUNCT;
        nxt = ALU_WB;
      end
      ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst = RD_RD;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op = ALU_SUB;
        bus.pc_src = PC_ALUOUT;
        bus.pc_write = bus.zero;
      end
      ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        nxt = ADDI_WB;
      end
      ADDI_WB: bus.reg_write = 1'b1;
      JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src = PC_JUMP;
      end
      JAL: begin
        bus.reg_write = 1'b1;
        bus.reg_dst = RD_RA;
        bus.memtoreg = MTR_PC4;
        bus.pc_write = 1'b1;
        bus.pc_src = PC_JUMP;
      end
      JR: begin
        bus.pc_write = 1'b1;
        bus.pc_src = PC_REG;
      end
      default: nxt = FETCH;
    endcase
  end
endmodule
